dt_phase_ctrl: RTL and testbench
================================

Name: dt_phase_ctrl

Overview:
Top-level sequencer for the distance-transform core. Drives the three pass engines (init, forward, backward) in strict order through an enable/done handshake. Owns the single res_RAM port and multiplexes each engine's address, data and strobes onto it. Also gates the sti_ROM read strobe, reports overall completion, and flags a hung phase through a per-phase watchdog.

Parameters:
AW, 14, res_RAM address width (128x128 image)
DW, 8, res_RAM data width
SAW, 10, sti_ROM address width
CW, 18, watchdog counter width
TIMEOUT, 18'h3FFFF, max cycles allowed in one active phase before error

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a run from IDLE
init_en  out  1  enable to init engine
init_done  in  1  init engine finished (level)
for_en  out  1  enable to forward-pass engine
for_done  in  1  forward pass finished (level)
back_en  out  1  enable to backward-pass engine
back_done  in  1  backward pass finished (level)
sti_addr_i  in  SAW  ROM address from init engine
sti_addr  out  SAW  ROM address to sti_ROM
sti_rd  out  1  ROM read strobe
res_addr_i/_f/_b  in  AW each  RAM address from init/forward/backward engine
res_do_i/_f/_b  in  DW each  write data from each engine
res_wr_f, res_wr_b, res_rd_f, res_rd_b  in  1 each  engine strobes (init always writes)
res_addr  out  AW  muxed RAM address
res_do  out  DW  muxed RAM write data
res_wr  out  1  muxed RAM write strobe
res_rd  out  1  muxed RAM read strobe
done  out  1  whole transform complete
err  out  1  watchdog expired
phase  out  3  current state encoding (debug)

Behaviour:
- States (phase code): IDLE 0, INIT 1, GAP1 2, FWD 3, GAP2 4, BWD 5, DONE 6, ERR 7. State register only; all outputs decoded combinationally from state (Moore).
- Reset (reset==0 at posedge): state<=IDLE, watchdog<=0. Resulting outputs: all enables 0, sti_rd 0, sti_addr 0, res_addr 0, res_do 0, res_wr 0, res_rd 0, done 0, err 0, phase 0. Reset mid-run aborts the run immediately; no drain.
- IDLE: start=1 -> INIT. Otherwise hold.
- INIT: init_en=1, sti_rd=1, sti_addr=sti_addr_i, res_addr=res_addr_i, res_do=res_do_i, res_wr=1, res_rd=0. init_done=1 -> GAP1. The mux stays on init during the cycle init_done is high, so the engine's final write (address 14'h3FFF) lands.
- GAP1 / GAP2: exactly one cycle; all enables and strobes 0, res_addr/res_do 0. Then FWD / BWD respectively. Gives engines one idle cycle to clear pipelined state.
- FWD: for_en=1; RAM port = forward-engine signals, including res_wr_f and res_rd_f. for_done=1 -> GAP2.
- BWD: back_en=1; RAM port = backward-engine signals. back_done=1 -> DONE.
- DONE: done=1, everything else idle. Held until reset. start is ignored.
- Done inputs from a non-active engine are ignored in every state. A done already high on the first cycle of its phase advances the state after that one cycle.
- start outside IDLE is ignored; no restart without reset.
- Watchdog:
  - Clears to 0 on every state change.
  - Increments each cycle in INIT/FWD/BWD while that phase's done is 0.
  - Saturates at all-ones.
  - Reaching TIMEOUT while the phase's done is still 0 -> ERR.
  - If done and expiry coincide, done wins and the normal transition is taken.
- ERR: err=1, all enables and strobes 0, done=0. Held until reset.
- sti_rd and sti_addr are driven only in INIT. Otherwise sti_addr=0.

Test Plan:
- Nominal run: stub engines raise done 16384 / 20 / 25 cycles after enable -> phase sequence 0,1,2,3,4,5,6; GAP states last exactly 1 cycle; done rises the cycle after back_done is sampled and stays high for 100 more cycles.
- Mux check: engines drive distinct patterns (init addr=cnt, data=cnt[0]; fwd addr=14'h1234, data=8'hAA, wr/rd toggling; bwd addr=14'h2BCD, data=8'h55) -> res_* match the active engine each cycle; all zero in GAP/IDLE/DONE. Last init write at 14'h3FFF is observed on the init_done cycle.
- Spurious done: for_done and back_done held 1 during INIT -> no skip; FWD entered only via GAP1 after init_done.
- Watchdog: TIMEOUT=100, for_done never asserts -> err=1 exactly 100 cycles after FWD entry; for_en=0 and res_wr=0 thereafter. Separately, for_done asserted on cycle 100 -> GAP2, err stays 0.
- Reset mid-BWD: reset low for one cycle during BWD -> next cycle phase=0 with all outputs at reset values; a new start reruns the full sequence correctly.
- start pulses during INIT and during DONE -> no effect on state or outputs.

Source files
------------

// File: rtl/dt_phase_ctrl.sv
// Phase sequencer for the distance-transform core: runs init, forward and backward
// engines in order, owns the res_RAM port mux, gates sti_ROM reads and watches for hangs.
module dt_phase_ctrl #(
  parameter int              AW      = 14,
  parameter int              DW      = 8,
  parameter int              SAW     = 10,
  parameter int              CW      = 18,
  parameter logic [CW-1:0]   TIMEOUT = 18'h3FFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            init_en,
  input  logic            init_done,
  output logic            for_en,
  input  logic            for_done,
  output logic            back_en,
  input  logic            back_done,
  input  logic [SAW-1:0]  sti_addr_i,
  output logic [SAW-1:0]  sti_addr,
  output logic            sti_rd,
  input  logic [AW-1:0]   res_addr_i,
  input  logic [AW-1:0]   res_addr_f,
  input  logic [AW-1:0]   res_addr_b,
  input  logic [DW-1:0]   res_do_i,
  input  logic [DW-1:0]   res_do_f,
  input  logic [DW-1:0]   res_do_b,
  input  logic            res_wr_f,
  input  logic            res_wr_b,
  input  logic            res_rd_f,
  input  logic            res_rd_b,
  output logic [AW-1:0]   res_addr,
  output logic [DW-1:0]   res_do,
  output logic            res_wr,
  output logic            res_rd,
  output logic            done,
  output logic            err,
  output logic [2:0]      phase
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_GAP1 = 3'd2;
  localparam logic [2:0] S_FWD  = 3'd3;
  localparam logic [2:0] S_GAP2 = 3'd4;
  localparam logic [2:0] S_BWD  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] wd_reg, wd_next;
  logic          phase_active;
  logic          phase_done;
  logic          wd_expire;

  // Only the engine owning the current phase can end it; other done lines are ignored.
  always_comb begin
    phase_active = 1'b0;
    phase_done   = 1'b0;
    case (state_reg)
      S_INIT: begin phase_active = 1'b1; phase_done = init_done; end
      S_FWD:  begin phase_active = 1'b1; phase_done = for_done;  end
      S_BWD:  begin phase_active = 1'b1; phase_done = back_done; end
      default: ;
    endcase
  end

  // Expiry fires on the cycle whose count would reach TIMEOUT.
  assign wd_expire = (({1'b0, wd_reg} + {{CW{1'b0}}, 1'b1}) >= {1'b0, TIMEOUT});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_INIT;
      S_INIT: begin
        if (phase_done)     state_next = S_GAP1;
        else if (wd_expire) state_next = S_ERR;
      end
      S_GAP1: state_next = S_FWD;
      S_FWD: begin
        if (phase_done)     state_next = S_GAP2;
        else if (wd_expire) state_next = S_ERR;
      end
      S_GAP2: state_next = S_BWD;
      S_BWD: begin
        if (phase_done)     state_next = S_DONE;
        else if (wd_expire) state_next = S_ERR;
      end
      S_DONE: state_next = S_DONE;
      S_ERR:  state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wd_next = wd_reg;
    if (state_next != state_reg)
      wd_next = '0;
    else if (phase_active && !phase_done && (wd_reg != {CW{1'b1}}))
      wd_next = wd_reg + {{(CW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
    end
  end

  // Moore output decode; every non-engine state parks the RAM and ROM ports at zero.
  always_comb begin
    init_en  = 1'b0;
    for_en   = 1'b0;
    back_en  = 1'b0;
    sti_rd   = 1'b0;
    sti_addr = '0;
    res_addr = '0;
    res_do   = '0;
    res_wr   = 1'b0;
    res_rd   = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_reg)
      S_INIT: begin
        init_en  = 1'b1;
        sti_rd   = 1'b1;
        sti_addr = sti_addr_i;
        res_addr = res_addr_i;
        res_do   = res_do_i;
        res_wr   = 1'b1;
      end
      S_FWD: begin
        for_en   = 1'b1;
        res_addr = res_addr_f;
        res_do   = res_do_f;
        res_wr   = res_wr_f;
        res_rd   = res_rd_f;
      end
      S_BWD: begin
        back_en  = 1'b1;
        res_addr = res_addr_b;
        res_do   = res_do_b;
        res_wr   = res_wr_b;
        res_rd   = res_rd_b;
      end
      S_DONE: done = 1'b1;
      S_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

  assign phase = state_reg;

endmodule

// File: tb/tb_dt_phase_ctrl.sv
// Bench for dt_phase_ctrl: two instances (default and short watchdog) checked every cycle
// against a phase-level reference model, plus directed literal checks.
module tb_dt_phase_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  logic [1:0]        rst_s, start_s;
  logic [1:0]        ien, fen, ben, idone, fdone, bdone;
  logic [1:0]        srd, rwr, rrd, dn, er;
  logic [1:0][2:0]   ph;
  logic [1:0][9:0]   saddr;
  logic [1:0][13:0]  raddr;
  logic [1:0][7:0]   rdo;
  logic [1:0][15:0]  cnt;
  logic [1:0][42:0]  got_v;
  int                ilen[2], flen[2], blen[2];
  logic              spur_f, spur_b;

  // Shared engine stubs, patterned from instance 0's phase counter.
  logic [9:0]  sti_addr_i;
  logic [13:0] res_addr_i, res_addr_f, res_addr_b;
  logic [7:0]  res_do_i, res_do_f, res_do_b;
  logic        res_wr_f, res_wr_b, res_rd_f, res_rd_b;
  assign sti_addr_i = cnt[0][9:0];
  assign res_addr_i = cnt[0][13:0];
  assign res_do_i   = {7'd0, cnt[0][0]};
  assign res_addr_f = 14'h1234;
  assign res_do_f   = 8'hAA;
  assign res_wr_f   = cnt[0][0];
  assign res_rd_f   = ~cnt[0][0];
  assign res_addr_b = 14'h2BCD;
  assign res_do_b   = 8'h55;
  assign res_wr_b   = ~cnt[0][0];
  assign res_rd_b   = cnt[0][1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stub
      always @(posedge clk)
        cnt[gi] <= (ien[gi] | fen[gi] | ben[gi]) ? cnt[gi] + 16'd1 : 16'd0;
      assign idone[gi] = ien[gi] && (ilen[gi] != 0) && (int'(cnt[gi]) == ilen[gi] - 1);
      assign fdone[gi] = (fen[gi] && (flen[gi] != 0) && (int'(cnt[gi]) == flen[gi] - 1))
                         || ((gi == 0) && spur_f);
      assign bdone[gi] = (ben[gi] && (blen[gi] != 0) && (int'(cnt[gi]) == blen[gi] - 1))
                         || ((gi == 0) && spur_b);
      assign got_v[gi] = {ph[gi], ien[gi], fen[gi], ben[gi], srd[gi], saddr[gi],
                          raddr[gi], rdo[gi], rwr[gi], rrd[gi], dn[gi], er[gi]};
    end
  endgenerate

  dt_phase_ctrl dut_a (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]),
    .init_en(ien[0]), .init_done(idone[0]), .for_en(fen[0]), .for_done(fdone[0]),
    .back_en(ben[0]), .back_done(bdone[0]),
    .sti_addr_i(sti_addr_i), .sti_addr(saddr[0]), .sti_rd(srd[0]),
    .res_addr_i(res_addr_i), .res_addr_f(res_addr_f), .res_addr_b(res_addr_b),
    .res_do_i(res_do_i), .res_do_f(res_do_f), .res_do_b(res_do_b),
    .res_wr_f(res_wr_f), .res_wr_b(res_wr_b), .res_rd_f(res_rd_f), .res_rd_b(res_rd_b),
    .res_addr(raddr[0]), .res_do(rdo[0]), .res_wr(rwr[0]), .res_rd(rrd[0]),
    .done(dn[0]), .err(er[0]), .phase(ph[0])
  );

  dt_phase_ctrl #(.TIMEOUT(18'd100)) dut_b (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]),
    .init_en(ien[1]), .init_done(idone[1]), .for_en(fen[1]), .for_done(fdone[1]),
    .back_en(ben[1]), .back_done(bdone[1]),
    .sti_addr_i(sti_addr_i), .sti_addr(saddr[1]), .sti_rd(srd[1]),
    .res_addr_i(res_addr_i), .res_addr_f(res_addr_f), .res_addr_b(res_addr_b),
    .res_do_i(res_do_i), .res_do_f(res_do_f), .res_do_b(res_do_b),
    .res_wr_f(res_wr_f), .res_wr_b(res_wr_b), .res_rd_f(res_rd_f), .res_rd_b(res_rd_b),
    .res_addr(raddr[1]), .res_do(rdo[1]), .res_wr(rwr[1]), .res_rd(rrd[1]),
    .done(dn[1]), .err(er[1]), .phase(ph[1])
  );

  // Reference model: phase number plus cycles spent in the current active phase.
  int mst[2] = '{0, 0};
  int mwd[2] = '{0, 0};
  int tmo[2] = '{262143, 100};

  function automatic int next_st(input int st, input int wd, input int t,
                                 input logic s, input logic id, input logic fd, input logic bd);
    logic dn_l;
    if (st == 0) return s ? 1 : 0;
    if (st == 2 || st == 4) return st + 1;
    if (st >= 6) return st;
    dn_l = (st == 1) ? id : (st == 3) ? fd : bd;
    if (dn_l) return st + 1;
    if (wd + 1 >= t) return 7;
    return st;
  endfunction

  function automatic logic [42:0] exp_outputs(input int st);
    logic [9:0]  sa;
    logic [13:0] ra;
    logic [7:0]  rd;
    logic        w, r;
    logic [2:0]  p;
    sa = '0; ra = '0; rd = '0; w = 1'b0; r = 1'b0;
    p = st[2:0];
    if (st == 1) begin sa = sti_addr_i; ra = res_addr_i; rd = res_do_i; w = 1'b1; end
    else if (st == 3) begin ra = res_addr_f; rd = res_do_f; w = res_wr_f; r = res_rd_f; end
    else if (st == 5) begin ra = res_addr_b; rd = res_do_b; w = res_wr_b; r = res_rd_b; end
    return {p, st == 1, st == 3, st == 5, st == 1, sa, ra, rd, w, r, st == 6, st == 7};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_s[k]) begin
        mst[k] <= 0;
        mwd[k] <= 0;
      end else begin
        mst[k] <= next_st(mst[k], mwd[k], tmo[k], start_s[k], idone[k], fdone[k], bdone[k]);
        if (next_st(mst[k], mwd[k], tmo[k], start_s[k], idone[k], fdone[k], bdone[k]) != mst[k])
          mwd[k] <= 0;
        else if (mst[k] == 1 || mst[k] == 3 || mst[k] == 5)
          mwd[k] <= (mwd[k] >= 262143) ? 262143 : mwd[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_v[k] !== exp_outputs(mst[k])) begin
          errors++;
          $display("FAIL model_cmp[%0d] t=%0t: got %h expected %h", k, $time, got_v[k],
                   exp_outputs(mst[k]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("check %s: %0h ok", name, got);
    end
  endtask

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    tick();
    start_s[k] = 1'b0;
  endtask

  task automatic wait_phase(input int k, input int p, input int maxc, input string name);
    for (int i = 0; i < maxc && int'(ph[k]) != p; i++) tick();
    check(name, 64'(ph[k]), 64'(p));
  endtask

  initial begin
    rst_s = 2'b00; start_s = 2'b00; spur_f = 1'b0; spur_b = 1'b0;
    ilen = '{16384, 5}; flen = '{20, 0}; blen = '{25, 3};
    tick();
    cmp_on = 1'b1;
    tick();
    check("reset_vec_a", 64'(got_v[0]), 64'd0);
    check("reset_vec_b", 64'(got_v[1]), 64'd0);
    rst_s = 2'b11;
    tick();

    // Nominal run with spurious done lines and a stray start during INIT.
    pulse_start(0);
    check("init_entry", 64'(ph[0]), 64'd1);
    spur_f = 1'b1; spur_b = 1'b1;
    repeat (5) tick();
    pulse_start(0);
    repeat (4) tick();
    spur_f = 1'b0; spur_b = 1'b0;
    check("spurious_no_skip", 64'(ph[0]), 64'd1);
    for (int i = 0; i < 20000 && !idone[0]; i++) tick();
    check("init_done_seen", 64'(idone[0]), 64'd1);
    check("last_init_write", 64'({raddr[0], rwr[0], ph[0]}), 64'({14'h3FFF, 1'b1, 3'd1}));
    tick();
    check("gap1_one_cycle", 64'(ph[0]), 64'd2);
    tick();
    check("fwd_entry", 64'(ph[0]), 64'd3);
    for (int i = 0; i < 100 && !fdone[0]; i++) tick();
    tick();
    check("gap2_one_cycle", 64'(ph[0]), 64'd4);
    tick();
    check("bwd_entry", 64'(ph[0]), 64'd5);
    for (int i = 0; i < 100 && !bdone[0]; i++) tick();
    check("done_low_on_back_done", 64'({dn[0], bdone[0]}), 64'b01);
    tick();
    check("done_rise", 64'({dn[0], ph[0]}), 64'({1'b1, 3'd6}));
    repeat (50) tick();
    pulse_start(0);
    repeat (50) tick();
    check("done_held", 64'({dn[0], ph[0]}), 64'({1'b1, 3'd6}));

    // Reset mid-BWD, then a full rerun.
    ilen[0] = 40;
    rst_s[0] = 1'b0; tick(); rst_s[0] = 1'b1; tick();
    pulse_start(0);
    wait_phase(0, 5, 500, "reach_bwd");
    repeat (3) tick();
    rst_s[0] = 1'b0;
    tick();
    check("reset_mid_bwd", 64'(got_v[0]), 64'd0);
    rst_s[0] = 1'b1;
    tick();
    pulse_start(0);
    wait_phase(0, 6, 500, "rerun_done");

    // Watchdog expiry with TIMEOUT=100.
    pulse_start(1);
    wait_phase(1, 3, 50, "wd_fwd_entry");
    repeat (99) tick();
    check("wd_before_expiry", 64'({er[1], ph[1]}), 64'({1'b0, 3'd3}));
    tick();
    check("wd_err", 64'({er[1], ph[1]}), 64'({1'b1, 3'd7}));
    repeat (5) tick();
    check("wd_err_idle", 64'({er[1], fen[1], rwr[1], dn[1]}), 64'b1000);

    // Done coinciding with expiry takes the normal transition.
    flen[1] = 100;
    rst_s[1] = 1'b0; tick(); rst_s[1] = 1'b1; tick();
    pulse_start(1);
    wait_phase(1, 3, 50, "wd2_fwd_entry");
    repeat (99) tick();
    check("wd2_last_fwd", 64'({er[1], ph[1]}), 64'({1'b0, 3'd3}));
    tick();
    check("wd2_coincide", 64'({er[1], ph[1]}), 64'({1'b0, 3'd4}));
    wait_phase(1, 6, 50, "wd2_done");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
